// File: rtl/gpio_pwm_csr.sv
// GPIO control/status block on the USI slave bus. Each channel runs in static, PWM or blink mode
// from a shared prescaler. Duty updates are shadowed so they only take effect at a period wrap.
module gpio_pwm_csr #(
  parameter int pBlockAdrsMap = 8,
  parameter int pAdrsMap      = 'h01,
  parameter int pBusAdrsBit   = 32,
  parameter int pChannels     = 8,
  parameter int pPrescaleRst  = 4
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic [31:0]            iSUsiWd,
  input  logic [pBusAdrsBit-1:0] iSUsiAdrs,
  input  logic                   iSUsiWCke,
  output logic [31:0]            oSUsiRd,
  output logic                   oSUsiVd,
  output logic [pChannels-1:0]   oGpio
);

  localparam logic [pBlockAdrsMap-1:0] BLK_SEL   = pBlockAdrsMap'(pAdrsMap);
  localparam logic [7:0]               OFF_OUT   = 8'h00;
  localparam logic [7:0]               OFF_MODE  = 8'h04;
  localparam logic [7:0]               OFF_PRESC = 8'h08;

  logic                   hit;
  logic [7:0]             off;
  logic                   wr;
  logic                   presc_wr;
  logic                   tick;
  logic                   wrap;
  logic [31:0]            rdata;

  logic [pChannels-1:0]   out_q, out_d;
  logic [2*pChannels-1:0] mode_q, mode_d;
  logic [15:0]            presc_q, presc_d;
  logic [7:0]             duty_q [pChannels];
  logic [7:0]             duty_d [pChannels];
  logic [7:0]             shadow_q [pChannels];
  logic [7:0]             shadow_d [pChannels];
  logic [15:0]            pc_q, pc_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [pChannels-1:0]   gpio_q, gpio_d;
  logic [31:0]            rd_q, rd_d;
  logic                   vd_q, vd_d;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{iSUsiAdrs, iSUsiWd};

  assign hit = (iSUsiAdrs[pBlockAdrsMap+7:8] == BLK_SEL);
  assign off = iSUsiAdrs[7:0];
  assign wr  = iSUsiWCke & hit;

  always_comb begin
    out_d    = out_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    duty_d   = duty_q;
    presc_wr = 1'b0;
    if (wr) begin
      case (off)
        OFF_OUT:   out_d = iSUsiWd[pChannels-1:0];
        OFF_MODE:  mode_d = iSUsiWd[2*pChannels-1:0];
        OFF_PRESC: begin
          presc_d  = iSUsiWd[15:0];
          presc_wr = 1'b1;
        end
        default: ;
      endcase
      for (int n = 0; n < pChannels; n++) begin
        if (off == 8'(16 + 4 * n)) duty_d[n] = iSUsiWd[7:0];
      end
    end
  end

  // Prescaler, period counter and shadow reload. The wrap tick samples the old DUTY value,
  // so a write landing on that same cycle waits for the following period.
  always_comb begin
    tick     = (pc_q == presc_q);
    pc_d     = (presc_wr || tick) ? 16'd0 : pc_q + 16'd1;
    cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
    wrap     = tick && (cnt_q == 8'hFF);
    shadow_d = wrap ? duty_q : shadow_q;
  end

  always_comb begin
    gpio_d = '0;
    for (int n = 0; n < pChannels; n++) begin
      case (mode_q[2*n +: 2])
        2'd1:    gpio_d[n] = (cnt_q < shadow_q[n]);
        2'd2:    gpio_d[n] = cnt_q[7];
        default: gpio_d[n] = out_q[n];
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT:   rdata[pChannels-1:0]   = out_q;
      OFF_MODE:  rdata[2*pChannels-1:0] = mode_q;
      OFF_PRESC: rdata[15:0]            = presc_q;
      default: ;
    endcase
    for (int n = 0; n < pChannels; n++) begin
      if (off == 8'(16 + 4 * n)) rdata[7:0] = duty_q[n];
    end
    rd_d = hit ? rdata : 32'd0;
    vd_d = hit;
  end

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      out_q   <= '1;
      mode_q  <= '0;
      presc_q <= 16'(pPrescaleRst);
      pc_q    <= '0;
      cnt_q   <= '0;
      gpio_q  <= '1;
      rd_q    <= '0;
      vd_q    <= 1'b0;
      for (int n = 0; n < pChannels; n++) begin
        duty_q[n]   <= '0;
        shadow_q[n] <= '0;
      end
    end else begin
      out_q    <= out_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      gpio_q   <= gpio_d;
      rd_q     <= rd_d;
      vd_q     <= vd_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
    end
  end

  assign oSUsiRd = rd_q;
  assign oSUsiVd = vd_q;
  assign oGpio   = gpio_q;

endmodule

// File: doc/gpio_pwm_csr.md
# gpio_pwm_csr

Parametrised GPIO control/status block on the USI slave bus, next generation of the fixed 8-LED GPIO register. Drives `pChannels` outputs, each independently in static, PWM or blink mode, from a shared programmable prescaler. Duty changes are double-buffered so they take effect only at a PWM period boundary, so outputs never glitch. It sits behind the bus slave decoder and drives board LEDs/GPIO pins directly.

## Interface
- `pBlockAdrsMap`, 8: width of the block-select field, `iSUsiAdrs[pBlockAdrsMap+7:8]`.
- `pAdrsMap`, 'h01: block-select value this instance responds to.
- `pBusAdrsBit`, 32: bus address width.
- `pChannels`, 8: number of GPIO channels, legal range 1..16.
- `pPrescaleRst`, 4: PRESCALE reset value. The tick period is PRESCALE+1 cycles, so 50 MHz / 5 = 10 MHz.

Ports:
- `iSysClk`, in, 1: the block's single clock.
- `iSysRst`, in, 1: reset, synchronous and active-high.
- `iSUsiWd`, in, 32: write data.
- `iSUsiAdrs`, in, pBusAdrsBit: read/write address.
- `iSUsiWCke`, in, 1: write enable.
- `oSUsiRd`, out, 32: read data.
- `oSUsiVd`, out, 1: read valid.
- `oGpio`, out, pChannels: registered GPIO outputs.

## Operation
- **Block hit:** `iSUsiAdrs[pBlockAdrsMap+7:8] == pAdrsMap`. The offset is `iSUsiAdrs[7:0]`.
- **Register map** (unused bits read 0):
  - 0x00 GPIO_OUT[pChannels-1:0]: static level. Resets to all ones.
  - 0x04 GPIO_MODE[2*pChannels-1:0]: 2 bits per channel. 0 = static, 1 = PWM, 2 = blink, 3 = treated as static. Resets to 0.
  - 0x08 PRESCALE[15:0]: resets to `pPrescaleRst`.
  - 0x10 + 4*n DUTY_n[7:0], for n < pChannels: resets to 0.
- **Writes:**
  - A write is performed when `iSUsiWCke` is high, the block hits and the offset is mapped. Writes to unmapped offsets are ignored.
  - A write to PRESCALE also clears the prescale counter.
- **Prescaler:**
  - 16-bit counter `pc`. When `pc == PRESCALE`, `tick` = 1 and `pc` goes to 0; otherwise `pc` increments.
  - PRESCALE = 0 gives a tick every cycle.
- **Period counter:** 8-bit `cnt` increments on `tick` and wraps from 255 to 0.
- **Duty shadow:**
  - `shadow_n` loads DUTY_n on the tick where `cnt` wraps from 255 to 0.
  - Reset clears the shadows.
  - Only shadows drive PWM.
- **Channel output function:**
  - static: GPIO_OUT[n].
  - PWM: `cnt < shadow_n`. Duty 0 gives constant 0; duty 255 gives high 255 of 256 ticks.
  - blink: `cnt[7]`, a 50 % square wave with a period of 256 ticks.
- **Readback:**
  - Returns programmed values, not shadows.
  - Any block hit, read or write, produces a read response.
  - Unmapped offsets return 0.
- **Mid-operation reset:** all state returns to its reset value on the next edge, whatever the mode or count.

## Timing
- **Reset values:**
  - `oGpio` = all ones.
  - `oSUsiRd` = 0, `oSUsiVd` = 0.
  - `pc`, `cnt` and the shadows = 0.
- **Write latency:**
  - A write sampled at edge N updates the CSR at edge N.
  - `oGpio` reflects it at edge N+1, which is 2 edges after `iSUsiWCke` is first presented.
- **Read latency:**
  - Address presented before edge N gives `oSUsiRd`/`oSUsiVd` valid after edge N.
  - `oSUsiVd` is high for exactly one cycle per cycle of block hit.
  - Back-to-back hits give a continuous `oSUsiVd`.
- **Simultaneous write and read of the same register:** `oSUsiRd` returns the pre-write value.
- **Simultaneous write of DUTY_n on the wrap tick:** the shadow loads the old DUTY_n; the new value applies at the next wrap.
- **Non-hit cycles:** `oSUsiRd` = 0, `oSUsiVd` = 0.
- **Outputs:** `oGpio` is always registered, with one cycle from internal state to pin.

## Test plan
- **Reset defaults:** release reset, then read 0x00, 0x04 and 0x08 -> 0x0000_00FF, 0x0, 0x4 (pChannels = 8). `oGpio` = 8'hFF, and `oSUsiVd` pulses once per read.
- **Static write:** write 0x00 = 0x5A -> `oGpio` = 8'h5A two edges after the write. A write to offset 0x0C is ignored and reads back 0.
- **PWM:**
  - Setup: PRESCALE = 0, DUTY_0 = 64, MODE = 1.
  - After the first wrap, ch0 is high for exactly 64 of every 256 cycles.
  - DUTY_0 = 0 gives constant low.
- **Duty change mid-period:**
  - Stimulus: change DUTY_0 from 64 to 200 at `cnt` = 100.
  - The current period still shows 64 high cycles, and the next period shows 200.
  - Readback of DUTY_0 = 200 immediately.
- **Blink with prescale:** PRESCALE = 4, MODE ch2 = 2 -> ch2 toggles every 640 cycles (128 ticks × 5).
- **Mid-operation reset:** assert `iSysRst` for 1 cycle during PWM -> next edge `oGpio` = all ones, MODE = 0, `pc`/`cnt` = 0, `oSUsiVd` = 0.
